// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  localparam int REG_AW = 5;
  localparam int REG_X0 = 0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_e;

endpackage : pipe_ctrl_pkg

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-facing bundle: hazard inputs from ID/EX/MEM and the per-stage control strobes.
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = pipe_ctrl_pkg::REG_AW
);

  logic [REG_AW-1:0] ifid_rs1_i;
  logic [REG_AW-1:0] ifid_rs2_i;
  logic              ifid_uses_rs2_i;
  logic              idex_memread_i;
  logic [REG_AW-1:0] idex_rd_i;
  logic              ex_branch_taken_i;
  logic              mem_access_i;
  logic              dmem_ready_i;

  logic              pc_write_o;
  logic              ifid_write_o;
  logic              ifid_flush_o;
  logic              idex_flush_o;
  logic              front_hold_o;
  logic              memwb_bubble_o;
  logic              dmem_valid_o;

  // The pipeline datapath side.
  modport master (
    output ifid_rs1_i, ifid_rs2_i, ifid_uses_rs2_i, idex_memread_i, idex_rd_i,
           ex_branch_taken_i, mem_access_i, dmem_ready_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o, front_hold_o,
           memwb_bubble_o, dmem_valid_o
  );

  // The hazard controller side.
  modport slave (
    input  ifid_rs1_i, ifid_rs2_i, ifid_uses_rs2_i, idex_memread_i, idex_rd_i,
           ex_branch_taken_i, mem_access_i, dmem_ready_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o, front_hold_o,
           memwb_bubble_o, dmem_valid_o
  );

endinterface : pipe_hazard_ctrl_if

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX whose destination feeds the instruction in ID.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = pipe_ctrl_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  input  logic              uses_rs2_i,
  input  logic              memread_i,
  input  logic [REG_AW-1:0] rd_i,
  output logic              load_use_o
);

  logic rd_live;
  logic src_match;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign rd_live    = (rd_i != REG_AW'(REG_X0));
  assign src_match  = (rd_i == rs1_i) | (uses_rs2_i & (rd_i == rs2_i));
  assign load_use_o = memread_i & rd_live & src_match;

endmodule : hazard_detect

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer: Mealy control strobes, memory-wait timeout FSM, saturating stall counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW  = pipe_ctrl_pkg::REG_AW,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  pipe_hazard_ctrl_if.slave ctrl,
  output logic             timeout_err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int                WAIT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              timeout_err_q, timeout_err_d;

  logic load_use;
  logic active;
  logic memstall;
  logic pc_write, ifid_write, ifid_flush, idex_flush;
  logic front_hold, memwb_bubble, dmem_valid;

  hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard_detect (
    .rs1_i      (ctrl.ifid_rs1_i),
    .rs2_i      (ctrl.ifid_rs2_i),
    .uses_rs2_i (ctrl.ifid_uses_rs2_i),
    .memread_i  (ctrl.idex_memread_i),
    .rd_i       (ctrl.idex_rd_i),
    .load_use_o (load_use)
  );

  assign active   = (state_q != ERR);
  assign memstall = active & ctrl.mem_access_i & ~ctrl.dmem_ready_i;

  // Strobes default to the frozen pattern shared by reset and ERR; reset gates them directly.
  always_comb begin
    pc_write     = 1'b0;
    ifid_write   = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    front_hold   = 1'b1;
    memwb_bubble = 1'b1;
    dmem_valid   = 1'b0;
    if (rst_i && active) begin
      dmem_valid = ctrl.mem_access_i;
      if (!memstall) begin
        front_hold   = 1'b0;
        memwb_bubble = 1'b0;
        if (ctrl.ex_branch_taken_i) begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (load_use) begin
          idex_flush = 1'b1;
        end else begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    stall_cnt_d   = stall_cnt_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      RUN: begin
        if (memstall) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (!memstall) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d       = ERR;
          timeout_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ERR:     state_d = ERR;
      default: state_d = RUN;
    endcase
    if (active && !pc_write && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      stall_cnt_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign ctrl.pc_write_o     = pc_write;
  assign ctrl.ifid_write_o   = ifid_write;
  assign ctrl.ifid_flush_o   = ifid_flush;
  assign ctrl.idex_flush_o   = idex_flush;
  assign ctrl.front_hold_o   = front_hold;
  assign ctrl.memwb_bubble_o = memwb_bubble;
  assign ctrl.dmem_valid_o   = dmem_valid;
  assign timeout_err_o       = timeout_err_q;
  assign stall_cnt_o         = stall_cnt_q;

endmodule : pipe_hazard_ctrl
